mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: RAM_LAT, default 1, cycles from ram_a presented to ram_din valid; only value 1 is supported.
REQ-002 clk_in  input  1  single clock; all state updates on posedge clk_in.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 rdy_in  input  1  chip-ready; when low, all state holds.
REQ-005 forward, rd_addr[4:0], rd_val[31:0]  input  from EX_MEM  writeback request, destination register, ALU result.
REQ-006 ins_type[6:0], ins_details[2:0]  input  from EX_MEM  opcode and funct3.
REQ-007 mem_addr[31:0], mem_val[31:0]  input  from EX_MEM  effective address and store data.
REQ-008 output_forward, output_rd_addr[4:0], output_rd_val[31:0]  output  to MEM_WB  writeback request, destination register, writeback value.
REQ-009 stall_req  output  1  freezes EX_MEM and all upstream stages while high.
REQ-010 mem_req  output  1  and mem_gnt  input  1  form the RAM-port arbitration handshake with the instruction fetch side.
REQ-011 ram_a[31:0]  output, ram_wr  output, ram_dout[7:0]  output, ram_din[7:0]  input  form a byte-wide RAM port.

Function
REQ-012 Memory op: ins_type==7'b0000011 (LOAD) or 7'b0100011 (STORE); all other ins_type values are non-memory ops.
REQ-013 Access length from ins_details[1:0]: 00=1 byte, 01=2 bytes, 1x=4 bytes.
REQ-014 Load extension: ins_details[2]==0 sign-extends from the top loaded byte; ins_details[2]==1 zero-extends.
REQ-015 Byte order is little-endian: byte i sits at mem_addr+i (32-bit wrap); no alignment check; misaligned accesses complete normally.
REQ-016 States: IDLE, REQ, ACCESS, WAIT, DONE; a byte counter cnt[2:0] and a 32-bit load buffer accompany them.
REQ-017 IDLE, non-memory op: outputs equal forward/rd_addr/rd_val combinationally; stall_req=0; no transition.
REQ-018 IDLE, memory op: stall_req=1 combinationally; next state REQ; cnt is cleared.
REQ-019 REQ: mem_req=1, stall_req=1; mem_gnt=1 moves to ACCESS next cycle; otherwise the block stays in REQ.
REQ-020 ACCESS: mem_req=1, stall_req=1, ram_a=mem_addr+cnt, cnt increments each cycle; exits after length cycles.
REQ-021 Store in ACCESS: ram_wr=1, ram_dout=mem_val[8*cnt+7:8*cnt]; next state after the last byte is DONE.
REQ-022 Load in ACCESS: ram_wr=0; for cnt>=1, ram_din is captured into buffer byte cnt-1; next state after the last address is WAIT.
REQ-023 WAIT (loads only): ram_din is captured into buffer byte length-1; mem_req=1, stall_req=1; next state DONE.
REQ-024 DONE: stall_req=0, mem_req=0, ram_wr=0; next state IDLE.
REQ-025 DONE, load: output_forward=forward, output_rd_addr=rd_addr, output_rd_val=extended buffer.
REQ-026 DONE, store: output_forward=0.
REQ-027 Outside DONE and the IDLE non-memory case, output_forward=0.
REQ-028 ram_wr is 1 only in ACCESS with a store and rdy_in=1; ram_a holds mem_addr+cnt whenever mem_req=1.
REQ-029 Latency with mem_gnt granted immediately: LW stalls 7 cycles (IDLE, REQ, 4 ACCESS, WAIT); SW stalls 6 cycles; LB stalls 4 cycles; SB stalls 3 cycles.
REQ-030 While rdy_in=0: state, cnt and buffer hold; ram_wr=0; combinational outputs keep their current values.
REQ-031 mem_gnt dropping during ACCESS or WAIT is ignored; the grant is held by the arbiter until mem_req falls.

Reset
REQ-032 When rst_in=1 at posedge: state=IDLE, cnt=0, buffer=0.
REQ-033 While rst_in=1: stall_req=0, mem_req=0, ram_wr=0, output_forward=0, output_rd_addr=0, output_rd_val=0.
REQ-034 Reset mid-operation abandons the access; bytes already written stay in RAM; there is no replay after reset.

Verification
REQ-035 ADDI forward=1, rd=5, rd_val=0x11 -> same cycle: output 1/5/0x11, stall_req=0.
REQ-036 LW addr 0x100, RAM bytes 0x78,0x56,0x34,0x12, gnt immediate -> ram_a 0x100..0x103 on consecutive cycles; DONE at cycle 7 with rd_val=0x12345678; stall_req high for 7 cycles.
REQ-037 LB/LBU addr 0x201, byte 0x80 -> LB rd_val=0xFFFFFF80; LBU rd_val=0x00000080.
REQ-038 SH addr 0x3FF, mem_val=0xAABBCCDD -> writes 0xDD@0x3FF and 0xCC@0x400; output_forward=0; stall_req high 4 cycles.
REQ-039 LW with mem_gnt held low 3 cycles -> stays in REQ 4 cycles; result 3 cycles later than in REQ-036; value correct.
REQ-040 rst_in asserted mid-SW after 2 bytes -> next cycle IDLE, all outputs 0; only 2 bytes modified; rdy_in=0 pulse mid-LW delays completion by 1 cycle with the same value.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: moves loads and stores one byte per cycle over a shared
// byte-wide RAM port, stalling the upstream pipeline until the access completes.
module mem_stage #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        forward,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_val,
    input  logic [6:0]  ins_type,
    input  logic [2:0]  ins_details,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_val,
    output logic        output_forward,
    output logic [4:0]  output_rd_addr,
    output logic [31:0] output_rd_val,
    output logic        stall_req,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] LAT      = 3'(RAM_LAT);

    typedef enum logic [2:0] {IDLE, REQ, ACCESS, WAIT, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] buffer;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic [1:0]  last_idx;
    logic [1:0]  cap_idx;
    logic        last_byte;
    logic [31:0] ext_val;

    assign is_load   = (ins_type == OP_LOAD);
    assign is_store  = (ins_type == OP_STORE);
    assign is_mem    = is_load | is_store;
    assign last_idx  = ins_details[1] ? 2'd3 : {1'b0, ins_details[0]};
    assign last_byte = (cnt == {1'b0, last_idx});
    // RAM data lags the address by LAT cycles, so the byte arriving now belongs to cnt-LAT
    assign cap_idx   = 2'(cnt - LAT);

    assign ram_a    = mem_addr + {29'd0, cnt};
    assign ram_dout = mem_val[{cnt[1:0], 3'b000} +: 8];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            buffer <= 32'd0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        state <= REQ;
                        cnt   <= 3'd0;
                    end
                end
                REQ: begin
                    if (mem_gnt) state <= ACCESS;
                end
                ACCESS: begin
                    if (is_load && cnt >= LAT) buffer[{cap_idx, 3'b000} +: 8] <= ram_din;
                    cnt <= cnt + 3'd1;
                    if (last_byte) state <= is_load ? WAIT : DONE;
                end
                WAIT: begin
                    buffer[{last_idx, 3'b000} +: 8] <= ram_din;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ext_val = buffer;
        if (!ins_details[1]) begin
            if (ins_details[0]) ext_val = {{16{buffer[15] & ~ins_details[2]}}, buffer[15:0]};
            else                ext_val = {{24{buffer[7] & ~ins_details[2]}}, buffer[7:0]};
        end
    end

    // Outputs decode the current state; reset forces every control and writeback output low
    always_comb begin
        output_forward = 1'b0;
        output_rd_addr = 5'd0;
        output_rd_val  = 32'd0;
        stall_req      = 1'b0;
        mem_req        = 1'b0;
        ram_wr         = 1'b0;
        if (!rst_in) begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        stall_req = 1'b1;
                    end else begin
                        output_forward = forward;
                        output_rd_addr = rd_addr;
                        output_rd_val  = rd_val;
                    end
                end
                REQ, WAIT: begin
                    mem_req   = 1'b1;
                    stall_req = 1'b1;
                end
                ACCESS: begin
                    mem_req   = 1'b1;
                    stall_req = 1'b1;
                    ram_wr    = is_store & rdy_in;
                end
                DONE: begin
                    if (is_load) begin
                        output_forward = forward;
                        output_rd_addr = rd_addr;
                        output_rd_val  = ext_val;
                    end
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed and random loads/stores against a RAM model
// and a byte-array reference of memory contents.
module tb_mem_stage;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, forward, mem_gnt;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val, mem_addr, mem_val;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic        output_forward, stall_req, mem_req, ram_wr;
    logic [4:0]  output_rd_addr;
    logic [31:0] output_rd_val, ram_a;
    logic [7:0]  ram_dout, ram_din;

    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    logic [31:0] trace [0:15];
    int          ntrace;
    int          errors = 0;
    int          checks = 0;
    int          last_stalls;
    logic [31:0] last_val;

    always #5 clk_in = ~clk_in;

    mem_stage #(.RAM_LAT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .forward(forward), .rd_addr(rd_addr), .rd_val(rd_val),
        .ins_type(ins_type), .ins_details(ins_details),
        .mem_addr(mem_addr), .mem_val(mem_val),
        .output_forward(output_forward), .output_rd_addr(output_rd_addr),
        .output_rd_val(output_rd_val), .stall_req(stall_req),
        .mem_req(mem_req), .mem_gnt(mem_gnt),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    // Synchronous byte RAM with one cycle read latency; it freezes with the chip when rdy_in is low
    always @(posedge clk_in) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (rdy_in) begin
            if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
            ram_din <= ram[ram_a[11:0]];
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic set_nop();
        ins_type = OP_ADDI; ins_details = 3'd0; forward = 1'b0;
        rd_addr = 5'd0; rd_val = 32'd0; mem_addr = 32'd0; mem_val = 32'd0; mem_gnt = 1'b0;
    endtask

    function automatic int access_len(input logic [2:0] det);
        return det[1] ? 4 : (det[0] ? 2 : 1);
    endfunction

    // Reference load: gather bytes little-endian from the memory image, then extend
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] det);
        logic [31:0] v, a;
        int n;
        n = access_len(det);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = v | (32'(shadow[a[11:0]]) << (8 * i));
        end
        if (!det[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic apply_stimulus(input logic [6:0] typ, input logic [2:0] det,
                                  input logic [31:0] addr, input logic [31:0] val,
                                  input logic [4:0] rd, input int gnt_delay, input int rdy_low_at,
                                  output int stalls, output logic fwd, output logic [4:0] ord,
                                  output logic [31:0] oval, output logic done);
        int req_seen;
        tick();
        ins_type = typ; ins_details = det; mem_addr = addr; mem_val = val;
        forward = 1'b1; rd_addr = rd; rd_val = $urandom; mem_gnt = 1'b0;
        stalls = 0; req_seen = 0; ntrace = 0;
        done = 1'b0; fwd = 1'b0; ord = 5'd0; oval = 32'd0;
        for (int c = 0; c < 40; c++) begin
            rdy_in = (c == rdy_low_at) ? 1'b0 : 1'b1;
            #1;
            if (!stall_req) begin
                done = 1'b1; fwd = output_forward; ord = output_rd_addr; oval = output_rd_val;
                break;
            end
            stalls++;
            if (mem_req && rdy_in) begin
                if (ntrace < 16) trace[ntrace] = ram_a;
                ntrace++;
                req_seen++;
            end
            mem_gnt = mem_req && (req_seen > gnt_delay);
            tick();
        end
        mem_gnt = 1'b0;
        rdy_in = 1'b1;
        tick();
        set_nop();
    endtask

    task automatic check_output(input string tag, input logic [6:0] typ, input logic [2:0] det,
                                input logic [31:0] addr, input logic [31:0] val,
                                input int gnt_delay, input int rdy_low_at);
        int n, bad;
        logic ld, fwd, done;
        logic [4:0] rd, ord;
        logic [31:0] exp_val, oval;
        n = access_len(det);
        ld = (typ == OP_LOAD);
        rd = 5'($urandom_range(1, 31));
        exp_val = model_load(addr, det);
        apply_stimulus(typ, det, addr, val, rd, gnt_delay, rdy_low_at,
                       last_stalls, fwd, ord, oval, done);
        last_val = oval;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stalls"}, last_stalls,
              (ld ? 3 : 2) + n + gnt_delay + ((rdy_low_at >= 0) ? 1 : 0));
        check({tag, "_fwd"}, 32'(fwd), 32'(ld));
        if (ld) begin
            check({tag, "_rd"}, 32'(ord), 32'(rd));
            check({tag, "_val"}, oval, exp_val);
        end else begin
            for (int i = 0; i < n; i++) shadow[12'(addr + 32'(i))] = val[8 * i +: 8];
            bad = 0;
            for (int i = 0; i < 4096; i++) if (ram[i] !== shadow[i]) bad++;
            check({tag, "_mem"}, bad, 0);
        end
        if (rdy_low_at < 0) begin
            for (int i = 0; i < n; i++)
                check({tag, "_ram_a"}, trace[gnt_delay + 1 + i], addr + 32'(i));
        end
    endtask

    initial begin
        logic [6:0]  typ_tab [0:7];
        logic [2:0]  det_tab [0:7];
        logic [7:0]  old2, old3;
        logic [6:0]  t;
        int sel, base, rlow, dly;

        typ_tab = '{OP_LOAD, OP_LOAD, OP_LOAD, OP_LOAD, OP_LOAD, OP_STORE, OP_STORE, OP_STORE};
        det_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};

        rst_in = 1'b1; rdy_in = 1'b1; pre_we = 1'b0; pre_addr = 12'd0; pre_data = 8'd0;
        set_nop();
        ins_type = OP_LOAD; forward = 1'b1; rd_addr = 5'd5; rd_val = 32'h11;
        for (int i = 0; i < 4096; i++) poke(12'(i), 8'($urandom));

        check("rst_fwd", 32'(output_forward), 32'd0);
        check("rst_rd", 32'(output_rd_addr), 32'd0);
        check("rst_val", output_rd_val, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_wr", 32'(ram_wr), 32'd0);

        tick();
        rst_in = 1'b0; ins_type = OP_ADDI;
        #1;
        check("addi_fwd", 32'(output_forward), 32'd1);
        check("addi_rd", 32'(output_rd_addr), 32'd5);
        check("addi_val", output_rd_val, 32'h11);
        check("addi_stall", 32'(stall_req), 32'd0);
        set_nop();

        poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
        poke(12'h201, 8'h80);

        check_output("lw", OP_LOAD, 3'b010, 32'h100, 32'd0, 0, -1);
        check("lw_const", last_val, 32'h1234_5678);
        check("lw_latency", last_stalls, 7);
        check_output("lb", OP_LOAD, 3'b000, 32'h201, 32'd0, 0, -1);
        check("lb_const", last_val, 32'hFFFF_FF80);
        check("lb_latency", last_stalls, 4);
        check_output("lbu", OP_LOAD, 3'b100, 32'h201, 32'd0, 0, -1);
        check("lbu_const", last_val, 32'h0000_0080);
        check_output("sh", OP_STORE, 3'b001, 32'h3FF, 32'hAABB_CCDD, 0, -1);
        check("sh_byte0", 32'(ram[12'h3FF]), 32'hDD);
        check("sh_byte1", 32'(ram[12'h400]), 32'hCC);
        check("sh_latency", last_stalls, 4);
        check_output("sw", OP_STORE, 3'b010, 32'h600, 32'h0102_0304, 0, -1);
        check("sw_latency", last_stalls, 6);
        check_output("sb", OP_STORE, 3'b000, 32'h700, 32'h0000_00A5, 0, -1);
        check("sb_latency", last_stalls, 3);
        check_output("lw_gnt", OP_LOAD, 3'b010, 32'h100, 32'd0, 3, -1);
        check("lw_gnt_const", last_val, 32'h1234_5678);
        check("lw_gnt_latency", last_stalls, 10);
        check_output("lw_rdy", OP_LOAD, 3'b010, 32'h100, 32'd0, 0, 4);
        check("lw_rdy_const", last_val, 32'h1234_5678);
        check("lw_rdy_latency", last_stalls, 8);
        check_output("lw_wrap", OP_LOAD, 3'b010, 32'hFFFF_FFFE, 32'd0, 1, -1);
        check_output("sw_wrap", OP_STORE, 3'b010, 32'hFFFF_FFFF, 32'hCAFE_F00D, 0, -1);

        // Reset lands on the third byte of a word store: only two bytes may reach RAM
        old2 = ram[12'h502]; old3 = ram[12'h503];
        tick();
        ins_type = OP_STORE; ins_details = 3'b010; mem_addr = 32'h500;
        mem_val = 32'h4433_2211; forward = 1'b1; mem_gnt = 1'b1;
        repeat (4) tick();
        rst_in = 1'b1;
        set_nop();
        forward = 1'b1; rd_addr = 5'd9; rd_val = 32'h55;
        #1;
        check("midrst_wr", 32'(ram_wr), 32'd0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_fwd", 32'(output_forward), 32'd0);
        check("midrst_rd", 32'(output_rd_addr), 32'd0);
        check("midrst_val", output_rd_val, 32'd0);
        tick();
        rst_in = 1'b0;
        set_nop();
        #1;
        check("postrst_stall", 32'(stall_req), 32'd0);
        check("postrst_req", 32'(mem_req), 32'd0);
        check("postrst_b0", 32'(ram[12'h500]), 32'h11);
        check("postrst_b1", 32'(ram[12'h501]), 32'h22);
        check("postrst_b2", 32'(ram[12'h502]), 32'(old2));
        check("postrst_b3", 32'(ram[12'h503]), 32'(old3));
        shadow[12'h500] = 8'h11;
        shadow[12'h501] = 8'h22;

        for (int k = 0; k < 6; k++) begin
            tick();
            do t = 7'($urandom); while (t == OP_LOAD || t == OP_STORE);
            ins_type = t; ins_details = 3'($urandom); forward = 1'($urandom);
            rd_addr = 5'($urandom); rd_val = $urandom; mem_addr = $urandom;
            #1;
            check("alu_fwd", 32'(output_forward), 32'(forward));
            check("alu_rd", 32'(output_rd_addr), 32'(rd_addr));
            check("alu_val", output_rd_val, rd_val);
            check("alu_stall", 32'(stall_req), 32'd0);
        end
        set_nop();

        for (int k = 0; k < 24; k++) begin
            sel  = $urandom_range(0, 7);
            dly  = $urandom_range(0, 3);
            base = ((typ_tab[sel] == OP_LOAD) ? 3 : 2) + access_len(det_tab[sel]) + dly;
            rlow = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, base - 1)) : -1;
            check_output("rand", typ_tab[sel], det_tab[sel], $urandom, $urandom, dly, rlow);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
